// File: rtl/fsm_probe_engine.sv
// Probe engine: replays a stored prefix into a target FSM, then tries each
// candidate byte and streams out those that move the target off its baseline.
module fsm_probe_engine #(
  parameter int DATA_W  = 7,
  parameter int STATE_W = 8,
  parameter int MAX_LEN = 64,
  parameter int CHAR_LO = 32,
  parameter int CHAR_HI = 125,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 2,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               first_only,
  input  logic               pfx_we,
  input  logic [DATA_W-1:0]  pfx_wdata,
  input  logic               pfx_clr,
  output logic [LEN_W-1:0]   pfx_len,
  output logic               pfx_ovf,
  output logic               busy,
  output logic               done,
  output logic               tgt_rst,
  output logic               tgt_en,
  output logic [DATA_W-1:0]  tgt_byte,
  input  logic [STATE_W-1:0] tgt_state,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [DATA_W-1:0]  hit_byte,
  output logic [7:0]         hit_count
);

  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMAX = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DATA_W-1:0] LO       = DATA_W'(CHAR_LO);
  localparam logic [DATA_W-1:0] HI       = DATA_W'(CHAR_HI);
  localparam logic [LEN_W-1:0]  FULL     = LEN_W'(MAX_LEN);
  localparam logic [CW-1:0]     RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]     SET_LAST = CW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_RST,
    S_REPLAY,
    S_PROBE,
    S_SETTLE,
    S_SAMPLE,
    S_EMIT
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0]  mem [MAX_LEN];
  logic [CW-1:0]      cnt;
  logic [LEN_W-1:0]   idx;
  logic [DATA_W-1:0]  cand;
  logic [STATE_W-1:0] base;
  logic               baseline;
  logic               first_q;
  logic               rst_pulse;
  logic               done_d;
  logic               idle;
  logic               emit_ok;
  logic               pfx_wr;

  assign idle    = (state == S_IDLE);
  assign emit_ok = (state == S_EMIT) && hit_ready;
  assign pfx_wr  = idle && pfx_we && !pfx_clr && (pfx_len != FULL);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    done_d    = 1'b0;
    busy      = !idle;
    tgt_rst   = rst_pulse || (state == S_T_RST);
    tgt_en    = 1'b0;
    tgt_byte  = '0;
    hit_valid = 1'b0;
    hit_byte  = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_T_RST;
      end
      S_T_RST: begin
        if (cnt == RST_LAST) begin
          if (pfx_len != '0) state_d = S_REPLAY;
          else if (baseline) state_d = S_SETTLE;
          else               state_d = S_PROBE;
        end
      end
      S_REPLAY: begin
        tgt_en   = 1'b1;
        tgt_byte = mem[idx[AW-1:0]];
        if (idx == pfx_len - LEN_W'(1))
          state_d = baseline ? S_SETTLE : S_PROBE;
      end
      S_PROBE: begin
        tgt_en   = 1'b1;
        tgt_byte = cand;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SET_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (baseline) begin
          state_d = S_T_RST;
        end else if (tgt_state != base) begin
          state_d = S_EMIT;
        end else if (cand == HI) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_T_RST;
        end
      end
      S_EMIT: begin
        hit_valid = 1'b1;
        hit_byte  = cand;
        if (hit_ready) begin
          if (first_q || cand == HI) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_T_RST;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      cand      <= '0;
      base      <= '0;
      baseline  <= 1'b0;
      first_q   <= 1'b0;
      hit_count <= '0;
      done      <= 1'b0;
      rst_pulse <= 1'b1;
    end else begin
      rst_pulse <= 1'b0;
      done      <= done_d;
      if ((state_d == state) &&
          (state == S_T_RST || state == S_SETTLE))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      idx <= (state == S_REPLAY) ? idx + LEN_W'(1) : '0;
      if (idle && start) begin
        first_q   <= first_only;
        hit_count <= '0;
        baseline  <= 1'b1;
        cand      <= LO;
      end
      if (state == S_SAMPLE) begin
        if (baseline) begin
          base     <= tgt_state;
          baseline <= 1'b0;
        end else if (state_d == S_T_RST) begin
          cand <= cand + DATA_W'(1);
        end
      end
      if (emit_ok) begin
        if (hit_count != 8'hff) hit_count <= hit_count + 8'd1;
        if (state_d == S_T_RST) cand <= cand + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pfx_len <= '0;
      pfx_ovf <= 1'b0;
    end else if (idle) begin
      if (pfx_clr) begin
        pfx_len <= '0;
        pfx_ovf <= 1'b0;
      end else if (pfx_we) begin
        if (pfx_len == FULL) pfx_ovf <= 1'b1;
        else                 pfx_len <= pfx_len + LEN_W'(1);
      end
    end
  end

  // Storage is deliberately left out of reset; pfx_len alone marks it valid.
  always_ff @(posedge clk) begin
    if (!rst && pfx_wr) mem[pfx_len[AW-1:0]] <= pfx_wdata;
  end

endmodule

// File: tb/tb_fsm_probe_engine.sv
// Bench for fsm_probe_engine: target FSM models, hit scoreboard, and
// cycle-level accounting of trials against a prefix-replay reference.
module tb_fsm_probe_engine;

  localparam int DW = 7;
  localparam int SW = 8;
  localparam int ML = 64;
  localparam int LO = 32;
  localparam int HI = 125;
  localparam int RC = 2;
  localparam int SC = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          first_only;
  logic          pfx_we;
  logic [DW-1:0] pfx_wdata;
  logic          pfx_clr;
  logic [LW-1:0] pfx_len;
  logic          pfx_ovf;
  logic          busy;
  logic          done;
  logic          tgt_rst;
  logic          tgt_en;
  logic [DW-1:0] tgt_byte;
  logic [SW-1:0] tgt_state;
  logic          hit_valid;
  logic          hit_ready;
  logic [DW-1:0] hit_byte;
  logic [7:0]    hit_count;

  int checks = 0;
  int failures = 0;
  int tmode = 0;
  int key = 0;
  int rdy_mode = 0;
  int wait_cnt = 0;
  int pfx_q[$];
  int exp_q[$];
  int busy_cyc, emit_cyc, en_cyc, done_cnt, viol;
  int cyc = 0;
  int hs_cyc = -100;
  int done_cyc = -1;
  logic          prev_v = 1'b0;
  logic          prev_acc = 1'b0;
  logic [DW-1:0] prev_b = '0;

  always #5 clk = ~clk;

  fsm_probe_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_only (first_only),
    .pfx_we     (pfx_we),
    .pfx_wdata  (pfx_wdata),
    .pfx_clr    (pfx_clr),
    .pfx_len    (pfx_len),
    .pfx_ovf    (pfx_ovf),
    .busy       (busy),
    .done       (done),
    .tgt_rst    (tgt_rst),
    .tgt_en     (tgt_en),
    .tgt_byte   (tgt_byte),
    .tgt_state  (tgt_state),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_byte   (hit_byte),
    .hit_count  (hit_count)
  );

  // Target behaviour: 0 = 'a' then 'b' chain, 1 = 'x'/'y' branch, 2 = keyed hash.
  function automatic int step(int s, int b);
    case (tmode)
      0: begin
        if (s == 0 && b == 97) return 1;
        if (s == 1 && b == 98) return 2;
        return s;
      end
      1: begin
        if (b == 120) return 10;
        if (b == 121) return 20;
        return s;
      end
      default: begin
        if (((b ^ key ^ s) & 15) == 0) return (s + b + 1) & 255;
        return s;
      end
    endcase
  endfunction

  function automatic int run(int q[$]);
    int s = 0;
    foreach (q[i]) s = step(s, q[i]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (tgt_rst)     tgt_state <= '0;
    else if (tgt_en) tgt_state <= SW'(step(int'(tgt_state), int'(tgt_byte)));
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    hit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: hit_ready = 1'b1;
        1: hit_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hit_valid) wait_cnt++;
          else           wait_cnt = 0;
          hit_ready = (wait_cnt > 10);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int e;
    cyc++;
    if (busy) busy_cyc++;
    if (hit_valid) emit_cyc++;
    if (tgt_en) en_cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!tgt_en && tgt_byte != '0) viol++;
    if (prev_v && !prev_acc) begin
      chk("hold_valid", 32'(hit_valid), 32'd1);
      chk("hold_byte", 32'(hit_byte), 32'(prev_b));
    end
    if (hit_valid && hit_ready) begin
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_hit actual=%0d required=none", hit_byte);
      end else begin
        e = exp_q.pop_front();
        chk("hit_byte", 32'(hit_byte), 32'(e));
      end
    end
    prev_v   = hit_valid;
    prev_acc = hit_valid && hit_ready;
    prev_b   = hit_byte;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int b);
    pfx_we = 1'b1;
    pfx_wdata = DW'(b);
    tick();
    pfx_we = 1'b0;
    if (pfx_q.size() < ML) pfx_q.push_back(b);
  endtask

  task automatic clr();
    pfx_clr = 1'b1;
    tick();
    pfx_clr = 1'b0;
    pfx_q.delete();
  endtask

  task automatic sweep(input bit fo, input int cw, input bit poke);
    int base, nt, hits, len, k, exp_busy;
    int q2[$];
    bit done_seen;
    if (cw >= 0 && pfx_q.size() < ML) pfx_q.push_back(cw);
    base = run(pfx_q);
    nt = 0;
    hits = 0;
    exp_q.delete();
    for (int c = LO; c <= HI; c++) begin
      q2 = pfx_q;
      q2.push_back(c);
      nt++;
      if (run(q2) != base) begin
        exp_q.push_back(c);
        hits++;
        if (fo) break;
      end
    end
    len = pfx_q.size();
    busy_cyc = 0;
    emit_cyc = 0;
    en_cyc = 0;
    done_cnt = 0;
    viol = 0;
    hs_cyc = -100;
    done_cyc = -1;
    start = 1'b1;
    first_only = fo;
    if (cw >= 0) begin
      pfx_we = 1'b1;
      pfx_wdata = DW'(cw);
    end
    tick();
    start = 1'b0;
    pfx_we = 1'b0;
    first_only = 1'($urandom_range(0, 1));
    k = $urandom_range(5, 40);
    done_seen = 1'b0;
    for (int i = 0; i < 30000 && !done_seen; i++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
      if (poke && i == k) begin
        start = 1'b1;
        pfx_we = 1'b1;
        pfx_wdata = DW'($urandom_range(LO, HI));
        pfx_clr = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
        pfx_we = 1'b0;
        pfx_clr = 1'b0;
      end
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    repeat (3) tick();
    exp_busy = (RC + len + SC + 1) + nt * (RC + len + 1 + SC + 1) + emit_cyc;
    chk("hits_left", 32'(exp_q.size()), 32'd0);
    chk("hit_count", 32'(hit_count), 32'((hits > 255) ? 255 : hits));
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
    chk("en_cycles", 32'(en_cyc), 32'(len + nt * (len + 1)));
    chk("idle_byte", 32'(viol), 32'd0);
    chk("pfx_len_kept", 32'(pfx_len), 32'(len));
    if (fo && hits > 0) chk("done_after_hs", 32'(done_cyc), 32'(hs_cyc + 1));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    first_only = 1'b0;
    pfx_we = 1'b0;
    pfx_clr = 1'b0;
    pfx_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit_valid", 32'(hit_valid), 32'd0);
    chk("rst_tgt_en", 32'(tgt_en), 32'd0);
    chk("rst_tgt_byte", 32'(tgt_byte), 32'd0);
    chk("rst_pfx_len", 32'(pfx_len), 32'd0);
    chk("rst_pfx_ovf", 32'(pfx_ovf), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("tgt_rst_after", 32'(tgt_rst), 32'd1);
    @(negedge clk);
    chk("tgt_rst_end", 32'(tgt_rst), 32'd0);
    tick();

    tmode = 0;
    rdy_mode = 0;
    clr();
    sweep(1'b0, 97, 1'b0);
    chk("chain_count", 32'(hit_count), 32'd1);

    tmode = 1;
    clr();
    sweep(1'b0, -1, 1'b1);
    chk("branch_count", 32'(hit_count), 32'd2);
    sweep(1'b1, -1, 1'b1);
    chk("first_only_count", 32'(hit_count), 32'd1);

    rdy_mode = 2;
    sweep(1'b0, -1, 1'b0);
    chk("stall_count", 32'(hit_count), 32'd2);

    rdy_mode = 1;
    tmode = 2;
    repeat (6) begin
      key = $urandom_range(0, 255);
      clr();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) wr($urandom_range(LO, HI));
      sweep(1'($urandom_range(0, 1)), -1, 1'b1);
    end
    rdy_mode = 0;

    clr();
    for (int i = 0; i < ML; i++) wr(LO + (i % 90));
    chk("full_len", 32'(pfx_len), 32'(ML));
    chk("full_no_ovf", 32'(pfx_ovf), 32'd0);
    wr(LO);
    chk("ovf_len", 32'(pfx_len), 32'(ML));
    chk("ovf_set", 32'(pfx_ovf), 32'd1);
    pfx_clr = 1'b1;
    pfx_we = 1'b1;
    tick();
    pfx_clr = 1'b0;
    pfx_we = 1'b0;
    pfx_q.delete();
    chk("clr_len", 32'(pfx_len), 32'd0);
    chk("clr_ovf", 32'(pfx_ovf), 32'd0);

    tmode = 0;
    for (int i = 0; i < 4; i++) wr(97);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tgt_en) break;
    end
    chk("mid_replay", 32'(tgt_en), 32'd1);
    pfx_clr = 1'b1;
    pfx_we = 1'b1;
    pfx_wdata = DW'(5);
    tick();
    pfx_clr = 1'b0;
    pfx_we = 1'b0;
    chk("busy_wr_ignored", 32'(pfx_len), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tgt_en", 32'(tgt_en), 32'd0);
    chk("abort_len", 32'(pfx_len), 32'd0);
    pfx_q.delete();
    tick();
    wr(97);
    sweep(1'b0, -1, 1'b0);
    chk("restart_count", 32'(hit_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
